// File: rtl/regfile_access_ctrl_if.sv
// Bus bundle between regfile_access_ctrl and its neighbours:
// issue requests, execute writebacks, register_block strobes and the operand buffer.
interface regfile_access_ctrl_if #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned NUM_REGS  = 64,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned TAG_W     = 4
);
  localparam int unsigned AW  = $clog2(NUM_REGS);
  localparam int unsigned WW  = $clog2(NUM_WARPS);
  localparam int unsigned LDW = NUM_LANES * DATA_W;

  logic                 iss_valid;
  logic                 iss_ready;
  logic [WW-1:0]        iss_warp;
  logic [AW-1:0]        iss_rs0;
  logic [AW-1:0]        iss_rs1;
  logic                 iss_use_rs1;
  logic [NUM_LANES-1:0] iss_lane_mask;
  logic [TAG_W-1:0]     iss_tag;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [WW-1:0]        wb_warp;
  logic [AW-1:0]        wb_rd;
  logic [NUM_LANES-1:0] wb_lane_mask;
  logic [LDW-1:0]       wb_data;

  logic [NUM_LANES-1:0] rb_read_en_0;
  logic [NUM_LANES-1:0] rb_read_en_1;
  logic [AW-1:0]        rb_raddr_0;
  logic [AW-1:0]        rb_raddr_1;
  logic [NUM_LANES-1:0] rb_write_en;
  logic [AW-1:0]        rb_waddr;
  logic [LDW-1:0]       rb_wdata;
  logic [WW-1:0]        rb_warp_sel;
  logic [LDW-1:0]       rb_rdata_0;
  logic [LDW-1:0]       rb_rdata_1;

  logic                 op_valid;
  logic                 op_ready;
  logic [LDW-1:0]       op_src0;
  logic [LDW-1:0]       op_src1;
  logic [WW-1:0]        op_warp;
  logic [TAG_W-1:0]     op_tag;

  // Controller side
  modport slave (
    input  iss_valid, iss_warp, iss_rs0, iss_rs1, iss_use_rs1, iss_lane_mask, iss_tag,
    output iss_ready,
    input  wb_valid, wb_warp, wb_rd, wb_lane_mask, wb_data,
    output wb_ready,
    output rb_read_en_0, rb_read_en_1, rb_raddr_0, rb_raddr_1,
    output rb_write_en, rb_waddr, rb_wdata, rb_warp_sel,
    input  rb_rdata_0, rb_rdata_1,
    output op_valid, op_src0, op_src1, op_warp, op_tag,
    input  op_ready
  );

  // Environment side (issue, execute, register_block)
  modport master (
    output iss_valid, iss_warp, iss_rs0, iss_rs1, iss_use_rs1, iss_lane_mask, iss_tag,
    input  iss_ready,
    output wb_valid, wb_warp, wb_rd, wb_lane_mask, wb_data,
    input  wb_ready,
    input  rb_read_en_0, rb_read_en_1, rb_raddr_0, rb_raddr_1,
    input  rb_write_en, rb_waddr, rb_wdata, rb_warp_sel,
    output rb_rdata_0, rb_rdata_1,
    input  op_valid, op_src0, op_src1, op_warp, op_tag,
    output op_ready
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: arbitrates writebacks against operand fetches on the
// shared warp selector, bypasses same-cycle writes into reads, and buffers one operand set.
module regfile_access_ctrl #(
  parameter int unsigned NUM_LANES    = 8,
  parameter int unsigned NUM_REGS     = 64,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NUM_WARPS    = 8,
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_access_ctrl_if.slave   bus
);
  localparam int unsigned AW  = $clog2(NUM_REGS);
  localparam int unsigned WW  = $clog2(NUM_WARPS);
  localparam int unsigned LDW = NUM_LANES * DATA_W;
  localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);

  logic                 w_buf_free;
  logic                 w_rd_ok;
  logic                 w_force_rd;
  logic                 w_wb_ready;
  logic                 w_iss_ready;
  logic                 w_rd1_en;
  logic [NUM_LANES-1:0] w_read_en_0;
  logic [NUM_LANES-1:0] w_read_en_1;
  logic [AW-1:0]        w_raddr_0;
  logic [AW-1:0]        w_raddr_1;
  logic [NUM_LANES-1:0] w_write_en;
  logic [AW-1:0]        w_waddr;
  logic [LDW-1:0]       w_wdata;
  logic [WW-1:0]        w_warp_sel;
  logic [LDW-1:0]       w_src0;
  logic [LDW-1:0]       w_src1;

  logic [SW-1:0]        r_starve_cnt;
  logic                 r_op_valid;
  logic [LDW-1:0]       r_op_src0;
  logic [LDW-1:0]       r_op_src1;
  logic [WW-1:0]        r_op_warp;
  logic [TAG_W-1:0]     r_op_tag;

  // Grant: writes win unless the read is starved; same-warp read and write share the selector
  always_comb begin
    w_buf_free  = !r_op_valid || bus.op_ready;
    w_rd_ok     = bus.iss_valid && w_buf_free;
    w_force_rd  = (r_starve_cnt == SW'(STARVE_LIMIT));
    w_wb_ready  = bus.wb_valid && !w_force_rd && !rst;
    w_iss_ready = w_rd_ok && !rst &&
                  (!w_wb_ready || (bus.wb_warp == bus.iss_warp) || w_force_rd);
    w_rd1_en    = w_iss_ready && bus.iss_use_rs1;
  end

  // register_block strobes, addresses and data; everything zero when not granted
  always_comb begin
    w_read_en_0 = '0;
    w_read_en_1 = '0;
    w_raddr_0   = '0;
    w_raddr_1   = '0;
    w_write_en  = '0;
    w_waddr     = '0;
    w_wdata     = '0;
    w_warp_sel  = '0;
    if (w_wb_ready) begin
      w_write_en = bus.wb_lane_mask;
      w_waddr    = bus.wb_rd;
      w_wdata    = bus.wb_data;
      w_warp_sel = bus.wb_warp;
    end else if (w_iss_ready) begin
      w_warp_sel = bus.iss_warp;
    end
    if (w_iss_ready) begin
      w_read_en_0 = bus.iss_lane_mask;
      w_raddr_0   = bus.iss_rs0;
    end
    if (w_rd1_en) begin
      w_read_en_1 = bus.iss_lane_mask;
      w_raddr_1   = bus.iss_rs1;
    end
  end

  // Operand select per lane: inactive lanes zero, same-cycle writes bypass the array
  always_comb begin
    w_src0 = '0;
    w_src1 = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (bus.iss_lane_mask[i]) begin
        if (w_wb_ready && bus.wb_lane_mask[i] && (bus.wb_rd == bus.iss_rs0))
          w_src0[i*DATA_W +: DATA_W] = bus.wb_data[i*DATA_W +: DATA_W];
        else
          w_src0[i*DATA_W +: DATA_W] = bus.rb_rdata_0[i*DATA_W +: DATA_W];
        if (bus.iss_use_rs1) begin
          if (w_wb_ready && bus.wb_lane_mask[i] && (bus.wb_rd == bus.iss_rs1))
            w_src1[i*DATA_W +: DATA_W] = bus.wb_data[i*DATA_W +: DATA_W];
          else
            w_src1[i*DATA_W +: DATA_W] = bus.rb_rdata_1[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Count consecutive cycles a ready-to-go read loses to a write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!bus.iss_valid || w_iss_ready) begin
      r_starve_cnt <= '0;
    end else if (w_rd_ok && !w_force_rd) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  // One-entry operand buffer; accept and drain in the same cycle keeps it full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_valid <= 1'b0;
      r_op_src0  <= '0;
      r_op_src1  <= '0;
      r_op_warp  <= '0;
      r_op_tag   <= '0;
    end else if (w_iss_ready) begin
      r_op_valid <= 1'b1;
      r_op_src0  <= w_src0;
      r_op_src1  <= w_src1;
      r_op_warp  <= bus.iss_warp;
      r_op_tag   <= bus.iss_tag;
    end else if (bus.op_ready) begin
      r_op_valid <= 1'b0;
    end
  end

  assign bus.iss_ready    = w_iss_ready;
  assign bus.wb_ready     = w_wb_ready;
  assign bus.rb_read_en_0 = w_read_en_0;
  assign bus.rb_read_en_1 = w_read_en_1;
  assign bus.rb_raddr_0   = w_raddr_0;
  assign bus.rb_raddr_1   = w_raddr_1;
  assign bus.rb_write_en  = w_write_en;
  assign bus.rb_waddr     = w_waddr;
  assign bus.rb_wdata     = w_wdata;
  assign bus.rb_warp_sel  = w_warp_sel;
  assign bus.op_valid     = r_op_valid;
  assign bus.op_src0      = r_op_src0;
  assign bus.op_src1      = r_op_src1;
  assign bus.op_warp      = r_op_warp;
  assign bus.op_tag       = r_op_tag;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register_block stand-in, per-cycle reference model and
// directed scenarios with literal expectations.
module tb_regfile_access_ctrl;
  localparam int unsigned NUM_LANES    = 8;
  localparam int unsigned NUM_REGS     = 64;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned NUM_WARPS    = 8;
  localparam int unsigned TAG_W        = 4;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned LDW          = NUM_LANES * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl_if #(
    .NUM_LANES(NUM_LANES), .NUM_REGS(NUM_REGS), .DATA_W(DATA_W),
    .NUM_WARPS(NUM_WARPS), .TAG_W(TAG_W)
  ) bus ();

  regfile_access_ctrl #(
    .NUM_LANES(NUM_LANES), .NUM_REGS(NUM_REGS), .DATA_W(DATA_W),
    .NUM_WARPS(NUM_WARPS), .TAG_W(TAG_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Power-on contents of every register lane
  function automatic logic [DATA_W-1:0] pat(input int w, input int r, input int l);
    return 32'h5000_0000 + 32'(w * 4096 + r * 16 + l);
  endfunction

  task automatic chk(input string name, input logic [LDW-1:0] act, input logic [LDW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // register_block stand-in: combinational read, posedge write, re-initialised during reset
  logic [DATA_W-1:0] env_mem [NUM_WARPS][NUM_REGS][NUM_LANES];

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < int'(NUM_WARPS); w++)
        for (int r = 0; r < int'(NUM_REGS); r++)
          for (int l = 0; l < int'(NUM_LANES); l++)
            env_mem[w][r][l] <= pat(w, r, l);
    end else begin
      for (int l = 0; l < int'(NUM_LANES); l++)
        if (bus.rb_write_en[l])
          env_mem[bus.rb_warp_sel][bus.rb_waddr][l] <= bus.rb_wdata[l*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    bus.rb_rdata_0 = '0;
    bus.rb_rdata_1 = '0;
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      bus.rb_rdata_0[l*DATA_W +: DATA_W] = env_mem[bus.rb_warp_sel][bus.rb_raddr_0][l];
      bus.rb_rdata_1[l*DATA_W +: DATA_W] = env_mem[bus.rb_warp_sel][bus.rb_raddr_1][l];
    end
  end

  // Reference model state: architectural register contents, buffer occupancy, loss streak
  logic [DATA_W-1:0] m_mem [NUM_WARPS][NUM_REGS][NUM_LANES];
  logic              m_valid = 1'b0;
  logic [LDW-1:0]    m_src0  = '0;
  logic [LDW-1:0]    m_src1  = '0;
  logic [2:0]        m_warp  = '0;
  logic [TAG_W-1:0]  m_tag   = '0;
  int                m_loss  = 0;

  logic              e_wb, e_iss, e_rdok;
  logic [7:0]        e_re0, e_re1, e_we;
  logic [5:0]        e_ra0, e_ra1, e_wa;
  logic [2:0]        e_sel;
  logic [LDW-1:0]    e_wdata, e_src0, e_src1;

  // Per-cycle comparison of all DUT outputs against the model, then model advance
  always @(negedge clk) begin
    e_rdok = bus.iss_valid && (!m_valid || bus.op_ready);
    e_wb   = bus.wb_valid && !rst && (m_loss < int'(STARVE_LIMIT));
    e_iss  = e_rdok && !rst && !(e_wb && (bus.wb_warp != bus.iss_warp));
    e_we    = e_wb ? bus.wb_lane_mask : 8'h00;
    e_wa    = e_wb ? bus.wb_rd : 6'd0;
    e_wdata = e_wb ? bus.wb_data : '0;
    e_re0   = e_iss ? bus.iss_lane_mask : 8'h00;
    e_ra0   = e_iss ? bus.iss_rs0 : 6'd0;
    e_re1   = (e_iss && bus.iss_use_rs1) ? bus.iss_lane_mask : 8'h00;
    e_ra1   = (e_iss && bus.iss_use_rs1) ? bus.iss_rs1 : 6'd0;
    e_sel   = e_wb ? bus.wb_warp : (e_iss ? bus.iss_warp : 3'd0);
    e_src0  = '0;
    e_src1  = '0;
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      if (bus.iss_lane_mask[l]) begin
        e_src0[l*DATA_W +: DATA_W] = (e_wb && bus.wb_lane_mask[l] && bus.wb_rd == bus.iss_rs0) ?
          bus.wb_data[l*DATA_W +: DATA_W] : m_mem[bus.iss_warp][bus.iss_rs0][l];
        if (bus.iss_use_rs1)
          e_src1[l*DATA_W +: DATA_W] = (e_wb && bus.wb_lane_mask[l] && bus.wb_rd == bus.iss_rs1) ?
            bus.wb_data[l*DATA_W +: DATA_W] : m_mem[bus.iss_warp][bus.iss_rs1][l];
      end
    end

    chk("iss_ready", LDW'(bus.iss_ready), LDW'(e_iss));
    chk("wb_ready", LDW'(bus.wb_ready), LDW'(e_wb));
    chk("rb_write_en", LDW'(bus.rb_write_en), LDW'(e_we));
    chk("rb_waddr", LDW'(bus.rb_waddr), LDW'(e_wa));
    chk("rb_wdata", bus.rb_wdata, e_wdata);
    chk("rb_read_en_0", LDW'(bus.rb_read_en_0), LDW'(e_re0));
    chk("rb_raddr_0", LDW'(bus.rb_raddr_0), LDW'(e_ra0));
    chk("rb_read_en_1", LDW'(bus.rb_read_en_1), LDW'(e_re1));
    chk("rb_raddr_1", LDW'(bus.rb_raddr_1), LDW'(e_ra1));
    chk("rb_warp_sel", LDW'(bus.rb_warp_sel), LDW'(e_sel));
    chk("op_valid", LDW'(bus.op_valid), LDW'(m_valid));
    chk("op_src0", bus.op_src0, m_src0);
    chk("op_src1", bus.op_src1, m_src1);
    chk("op_warp", LDW'(bus.op_warp), LDW'(m_warp));
    chk("op_tag", LDW'(bus.op_tag), LDW'(m_tag));

    if (rst) begin
      m_valid = 1'b0; m_src0 = '0; m_src1 = '0; m_warp = '0; m_tag = '0; m_loss = 0;
      for (int w = 0; w < int'(NUM_WARPS); w++)
        for (int r = 0; r < int'(NUM_REGS); r++)
          for (int l = 0; l < int'(NUM_LANES); l++)
            m_mem[w][r][l] = pat(w, r, l);
    end else begin
      if (e_iss) begin
        m_valid = 1'b1; m_src0 = e_src0; m_src1 = e_src1;
        m_warp = bus.iss_warp; m_tag = bus.iss_tag;
      end else if (bus.op_ready) begin
        m_valid = 1'b0;
      end
      if (e_wb)
        for (int l = 0; l < int'(NUM_LANES); l++)
          if (bus.wb_lane_mask[l])
            m_mem[bus.wb_warp][bus.wb_rd][l] = bus.wb_data[l*DATA_W +: DATA_W];
      if (!bus.iss_valid || e_iss) m_loss = 0;
      else if (e_rdok && m_loss < int'(STARVE_LIMIT)) m_loss = m_loss + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic [2:0] w, input logic [5:0] rd, input logic [7:0] m,
                        input logic [DATA_W-1:0] base);
    bus.wb_valid = 1'b1; bus.wb_warp = w; bus.wb_rd = rd; bus.wb_lane_mask = m;
    for (int l = 0; l < int'(NUM_LANES); l++)
      bus.wb_data[l*DATA_W +: DATA_W] = base + DATA_W'(l);
  endtask

  task automatic set_iss(input logic [2:0] w, input logic [5:0] rs0, input logic [5:0] rs1,
                         input logic use1, input logic [7:0] m, input logic [3:0] tag);
    bus.iss_valid = 1'b1; bus.iss_warp = w; bus.iss_rs0 = rs0; bus.iss_rs1 = rs1;
    bus.iss_use_rs1 = use1; bus.iss_lane_mask = m; bus.iss_tag = tag;
  endtask

  logic [LDW-1:0] lit0, lit1;

  initial begin
    bus.iss_valid = 1'b0; bus.iss_warp = '0; bus.iss_rs0 = '0; bus.iss_rs1 = '0;
    bus.iss_use_rs1 = 1'b0; bus.iss_lane_mask = '0; bus.iss_tag = '0;
    bus.wb_valid = 1'b0; bus.wb_warp = '0; bus.wb_rd = '0; bus.wb_lane_mask = '0;
    bus.wb_data = '0; bus.op_ready = 1'b1;

    // Reset with both requesters active: nothing granted, buffer empty
    set_wb(3'd1, 6'd2, 8'hFF, 32'h0);
    set_iss(3'd1, 6'd2, 6'd3, 1'b1, 8'hFF, 4'd1);
    repeat (2) begin
      @(negedge clk);
      chk("rst iss_ready", LDW'(bus.iss_ready), '0);
      chk("rst wb_ready", LDW'(bus.wb_ready), '0);
      chk("rst op_valid", LDW'(bus.op_valid), '0);
      chk("rst rb_write_en", LDW'(bus.rb_write_en), '0);
      chk("rst rb_read_en_0", LDW'(bus.rb_read_en_0), '0);
      tick();
    end
    rst = 1'b0; bus.iss_valid = 1'b0; bus.wb_valid = 1'b0;
    tick();

    // Write warp3 r5, then read it back on both ports
    set_wb(3'd3, 6'd5, 8'hFF, 32'hA0);
    @(negedge clk);
    chk("t2 rb_write_en", LDW'(bus.rb_write_en), LDW'(8'hFF));
    chk("t2 rb_warp_sel", LDW'(bus.rb_warp_sel), LDW'(3'd3));
    tick();
    bus.wb_valid = 1'b0;
    set_iss(3'd3, 6'd5, 6'd5, 1'b1, 8'hFF, 4'd9);
    tick();
    bus.iss_valid = 1'b0;
    for (int l = 0; l < 8; l++) lit0[l*32 +: 32] = 32'hA0 + 32'(l);
    @(negedge clk);
    chk("t2 op_valid", LDW'(bus.op_valid), LDW'(1'b1));
    chk("t2 op_src0", bus.op_src0, lit0);
    chk("t2 op_src1", bus.op_src1, lit0);
    chk("t2 op_tag", LDW'(bus.op_tag), LDW'(4'd9));
    tick();

    // Same-warp write and read in one cycle: partial-lane bypass
    set_wb(3'd2, 6'd7, 8'h0F, 32'h11);
    set_iss(3'd2, 6'd7, 6'd0, 1'b0, 8'hFF, 4'd3);
    @(negedge clk);
    chk("t3 wb_ready", LDW'(bus.wb_ready), LDW'(1'b1));
    chk("t3 iss_ready", LDW'(bus.iss_ready), LDW'(1'b1));
    chk("t3 rb_write_en", LDW'(bus.rb_write_en), LDW'(8'h0F));
    tick();
    bus.wb_valid = 1'b0; bus.iss_valid = 1'b0;
    for (int l = 0; l < 4; l++) lit0[l*32 +: 32] = 32'h11 + 32'(l);
    for (int l = 4; l < 8; l++) lit0[l*32 +: 32] = 32'h5000_2070 + 32'(l);
    @(negedge clk);
    chk("t3 op_src0", bus.op_src0, lit0);
    chk("t3 op_src1", bus.op_src1, '0);
    tick();

    // Different-warp contention: read starves four cycles, then is forced through
    set_wb(3'd1, 6'd9, 8'hFF, 32'hB0);
    set_iss(3'd4, 6'd3, 6'd4, 1'b1, 8'hFF, 4'd5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4 starve iss_ready", LDW'(bus.iss_ready), '0);
      chk("t4 starve wb_ready", LDW'(bus.wb_ready), LDW'(1'b1));
      tick();
    end
    @(negedge clk);
    chk("t4 forced iss_ready", LDW'(bus.iss_ready), LDW'(1'b1));
    chk("t4 forced wb_ready", LDW'(bus.wb_ready), '0);
    chk("t4 forced warp_sel", LDW'(bus.rb_warp_sel), LDW'(3'd4));
    tick();
    bus.iss_valid = 1'b0;
    for (int l = 0; l < 8; l++) begin
      lit0[l*32 +: 32] = 32'h5000_4030 + 32'(l);
      lit1[l*32 +: 32] = 32'h5000_4040 + 32'(l);
    end
    @(negedge clk);
    chk("t4 wb resumes", LDW'(bus.wb_ready), LDW'(1'b1));
    chk("t4 op_src0", bus.op_src0, lit0);
    chk("t4 op_src1", bus.op_src1, lit1);
    tick();
    bus.wb_valid = 1'b0;

    // Backpressure holds the buffer, then back-to-back accepts without a bubble
    bus.op_ready = 1'b0;
    set_iss(3'd0, 6'd1, 6'd0, 1'b0, 8'hFF, 4'd1);
    tick();
    set_iss(3'd0, 6'd2, 6'd0, 1'b0, 8'hFF, 4'd2);
    repeat (3) begin
      @(negedge clk);
      chk("t5 hold iss_ready", LDW'(bus.iss_ready), '0);
      chk("t5 hold op_tag", LDW'(bus.op_tag), LDW'(4'd1));
      tick();
    end
    bus.op_ready = 1'b1;
    @(negedge clk);
    chk("t5 release iss_ready", LDW'(bus.iss_ready), LDW'(1'b1));
    tick();
    set_iss(3'd0, 6'd3, 6'd0, 1'b0, 8'hFF, 4'd3);
    @(negedge clk);
    chk("t5 b2b op_valid", LDW'(bus.op_valid), LDW'(1'b1));
    chk("t5 b2b op_tag", LDW'(bus.op_tag), LDW'(4'd2));
    tick();
    bus.iss_valid = 1'b0;
    @(negedge clk);
    chk("t5 last op_tag", LDW'(bus.op_tag), LDW'(4'd3));
    tick();

    // Sparse lane mask, port 1 unused
    set_iss(3'd5, 6'd2, 6'd6, 1'b0, 8'h81, 4'd6);
    @(negedge clk);
    chk("t6 rb_read_en_0", LDW'(bus.rb_read_en_0), LDW'(8'h81));
    chk("t6 rb_read_en_1", LDW'(bus.rb_read_en_1), '0);
    tick();
    bus.iss_valid = 1'b0;
    lit0 = '0;
    lit0[31:0]    = 32'h5000_5020;
    lit0[255:224] = 32'h5000_5027;
    @(negedge clk);
    chk("t6 op_src0", bus.op_src0, lit0);
    chk("t6 op_src1", bus.op_src1, '0);
    tick();

    // Empty-mask writeback completes without changing the register
    set_wb(3'd6, 6'd1, 8'h00, 32'hDEAD_0000);
    @(negedge clk);
    chk("t7 wb_ready", LDW'(bus.wb_ready), LDW'(1'b1));
    chk("t7 rb_write_en", LDW'(bus.rb_write_en), '0);
    tick();
    bus.wb_valid = 1'b0;
    set_iss(3'd6, 6'd1, 6'd0, 1'b0, 8'hFF, 4'd7);
    tick();
    bus.iss_valid = 1'b0;
    for (int l = 0; l < 8; l++) lit0[l*32 +: 32] = 32'h5000_6010 + 32'(l);
    @(negedge clk);
    chk("t7 op_src0", bus.op_src0, lit0);
    tick();

    // Mixed traffic with intermittent backpressure, checked by the model only
    for (int k = 0; k < 40; k++) begin
      bus.iss_valid = (k % 3) != 0;
      bus.iss_warp = 3'(k % 4); bus.iss_rs0 = 6'(k % 8); bus.iss_rs1 = 6'((k + 3) % 8);
      bus.iss_use_rs1 = k[1]; bus.iss_lane_mask = 8'(8'hA5 ^ 8'(k * 7)); bus.iss_tag = 4'(k);
      bus.wb_valid = (k % 2) != 0;
      bus.wb_warp = 3'((k / 2) % 4); bus.wb_rd = 6'((k + 1) % 8);
      bus.wb_lane_mask = 8'(8'h3C ^ 8'(k * 5));
      for (int l = 0; l < 8; l++) bus.wb_data[l*32 +: 32] = 32'(k * 256 + l);
      bus.op_ready = (k % 5) != 0;
      tick();
    end
    bus.iss_valid = 1'b0; bus.wb_valid = 1'b0; bus.op_ready = 1'b1;
    tick();

    // Reset while the buffer holds an operand set discards it
    bus.op_ready = 1'b0;
    set_iss(3'd7, 6'd4, 6'd0, 1'b0, 8'hFF, 4'd7);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t8 pre-rst op_valid", LDW'(bus.op_valid), LDW'(1'b1));
    chk("t8 rst iss_ready", LDW'(bus.iss_ready), '0);
    tick();
    @(negedge clk);
    chk("t8 op_valid", LDW'(bus.op_valid), '0);
    chk("t8 op_tag", LDW'(bus.op_tag), '0);
    tick();
    rst = 1'b0; bus.iss_valid = 1'b0; bus.op_ready = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
